contador_multi: RTL and testbench

- Parametrised, multi-channel event counter; successor to the fixed five-FIFO push counter.
- Counts push pulses from NUM_CH FIFOs, one counter per channel.
- Two read modes, both through a req/idx handshake:
  - single-channel read;
  - sweep read that streams every channel on consecutive cycles.
- Adds overflow policy (wrap or saturate), sticky per-channel overflow flags and optional clear-on-read; sits between the FIFO bank and the test/monitor logic.

---
 rtl/contador_multi.sv | 141 ++++++++++++++
 tb/tb_contador_multi.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/contador_multi.sv
// ============================================================================
// Module   : contador_multi
// Summary  : Multi-channel push counter with single and sweep reads, overflow
//            policy, sticky overflow flags and optional clear-on-read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module contador_multi #(
  parameter int NUM_CH      = 5,
  parameter int IDX_W       = 3,
  parameter int COUNT_W     = 6,
  parameter int SATURATE    = 0,
  parameter int CLR_ON_READ = 0
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic [NUM_CH-1:0]  push,
  input  logic               req,
  input  logic [IDX_W-1:0]   idx,
  output logic [COUNT_W-1:0] data,
  output logic               valid,
  output logic               busy,
  output logic [NUM_CH-1:0]  ovf
);

  localparam logic [IDX_W-1:0]   c_num_ch  = IDX_W'(NUM_CH);
  localparam logic [IDX_W-1:0]   c_last_ch = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0]   c_ptr_one = IDX_W'(1);
  localparam logic [COUNT_W-1:0] c_max     = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] c_one     = COUNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [COUNT_W-1:0]   data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic [COUNT_W-1:0]   cnt_q [NUM_CH];
  logic [COUNT_W-1:0]   cnt_d [NUM_CH];
  logic [NUM_CH-1:0]    ovf_q, ovf_d;
  logic                 w_rd_en;
  logic [IDX_W-1:0]     w_rd_ch;

  // Read control; busy_q also blocks the cycle in which the last sweep word is shown.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    w_rd_en = 1'b0;
    w_rd_ch = '0;
    case (state_q)
      S_IDLE: begin
        if (req && !busy_q) begin
          if (idx < c_num_ch) begin
            w_rd_en = 1'b1;
            w_rd_ch = idx;
          end else if (idx == c_num_ch) begin
            w_rd_en = 1'b1;
            w_rd_ch = '0;
            busy_d  = 1'b1;
            ptr_d   = c_ptr_one;
            state_d = S_SWEEP;
          end
        end
      end
      S_SWEEP: begin
        w_rd_en = 1'b1;
        w_rd_ch = ptr_q;
        busy_d  = 1'b1;
        ptr_d   = ptr_q + c_ptr_one;
        if (ptr_q == c_last_ch) begin
          state_d = S_IDLE;
          ptr_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (w_rd_en) begin
      data_d  = cnt_q[w_rd_ch];
      valid_d = 1'b1;
    end
  end

  // A clearing read restarts the counter from this edge's push, never flagging overflow.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i];
      if ((CLR_ON_READ != 0) && w_rd_en && (w_rd_ch == IDX_W'(i))) begin
        cnt_d[i] = {{(COUNT_W-1){1'b0}}, push[i]};
        ovf_d[i] = 1'b0;
      end else if (push[i]) begin
        if (cnt_q[i] == c_max) begin
          ovf_d[i] = 1'b1;
          cnt_d[i] = (SATURATE != 0) ? c_max : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + c_one;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign ovf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_contador_multi.sv
// ============================================================================
// Module   : tb_contador_multi
// Summary  : Directed bench; wrap, saturate and clear-on-read variants share stimulus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_contador_multi;

  logic       clk;
  logic       reset_L;
  logic [4:0] push;
  logic       req;
  logic [2:0] idx;

  logic [5:0] w_data,  s_data,  c_data;
  logic       w_valid, s_valid, c_valid;
  logic       w_busy,  s_busy,  c_busy;
  logic [4:0] w_ovf,   s_ovf,   c_ovf;

  int n_cmp = 0;
  int n_err = 0;

  contador_multi #(.NUM_CH(5), .IDX_W(3), .COUNT_W(6), .SATURATE(0), .CLR_ON_READ(0)) u_wrap (
    .clk(clk), .reset_L(reset_L), .push(push), .req(req), .idx(idx),
    .data(w_data), .valid(w_valid), .busy(w_busy), .ovf(w_ovf));

  contador_multi #(.NUM_CH(5), .IDX_W(3), .COUNT_W(6), .SATURATE(1), .CLR_ON_READ(0)) u_sat (
    .clk(clk), .reset_L(reset_L), .push(push), .req(req), .idx(idx),
    .data(s_data), .valid(s_valid), .busy(s_busy), .ovf(s_ovf));

  contador_multi #(.NUM_CH(5), .IDX_W(3), .COUNT_W(6), .SATURATE(0), .CLR_ON_READ(1)) u_clr (
    .clk(clk), .reset_L(reset_L), .push(push), .req(req), .idx(idx),
    .data(c_data), .valid(c_valid), .busy(c_busy), .ovf(c_ovf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    push    = '0;
    req     = 1'b0;
    tick();
    reset_L = 1'b1;
  endtask

  initial begin
    // Reset held two cycles with every input active
    reset_L = 1'b0; push = 5'h1f; req = 1'b1; idx = 3'd2;
    tick(2);
    chk("rst_data",  w_data,  0);
    chk("rst_valid", w_valid, 0);
    chk("rst_busy",  w_busy,  0);
    chk("rst_ovf",   w_ovf,   0);
    reset_L = 1'b1; push = '0; req = 1'b0;
    tick();
    req = 1'b1; idx = 3'd2;
    tick();
    chk("rst_nocount_data",  w_data,  0);
    chk("rst_nocount_valid", w_valid, 1);
    req = 1'b0;

    // Single read of channel 2 after 7 pushes
    push = 5'b00100;
    tick(7);
    push = '0;
    req = 1'b1; idx = 3'd2;
    tick();
    chk("single_data",  w_data,  7);
    chk("single_valid", w_valid, 1);
    chk("single_busy",  w_busy,  0);
    req = 1'b0;
    tick();
    chk("single_valid_drop", w_valid, 0);
    chk("single_data_hold",  w_data,  7);
    req = 1'b1; idx = 3'd6;
    tick();
    chk("bad_idx_valid", w_valid, 0);
    chk("bad_idx_busy",  w_busy,  0);
    req = 1'b0;

    // Sweep: channel k holds k+1; a req held during the sweep is ignored
    do_reset();
    push = 5'b11111; tick();
    push = 5'b11110; tick();
    push = 5'b11100; tick();
    push = 5'b11000; tick();
    push = 5'b10000; tick();
    push = '0;
    req = 1'b1; idx = 3'd5;
    tick();
    req = 1'b1; idx = 3'd2;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("sweep_data%0d", k),  w_data,  k + 1);
      chk($sformatf("sweep_valid%0d", k), w_valid, 1);
      chk($sformatf("sweep_busy%0d", k),  w_busy,  1);
      chk($sformatf("sweep_sat_data%0d", k), s_data, k + 1);
      tick();
    end
    chk("sweep_end_valid", w_valid, 0);
    chk("sweep_end_busy",  w_busy,  0);
    chk("sweep_end_data",  w_data,  5);
    req = 1'b0;

    // Overflow: 65 pushes on channel 0
    do_reset();
    push = 5'b00001;
    tick(65);
    push = '0;
    chk("ovf_wrap_flag", w_ovf, 5'b00001);
    chk("ovf_sat_flag",  s_ovf, 5'b00001);
    req = 1'b1; idx = 3'd0;
    tick();
    req = 1'b0;
    chk("ovf_wrap_data", w_data, 1);
    chk("ovf_sat_data",  s_data, 63);
    chk("ovf_wrap_sticky", w_ovf, 5'b00001);
    chk("ovf_clr_cleared", c_ovf, 5'b00000);

    // Clear-on-read with a push on the same edge
    do_reset();
    push = 5'b00010;
    tick(10);
    req = 1'b1; idx = 3'd1; push = 5'b00010;
    tick();
    chk("cor_data",      c_data, 10);
    chk("cor_wrap_data", w_data, 10);
    push = '0;
    tick();
    req = 1'b0;
    chk("cor_reread",      c_data, 1);
    chk("cor_reread_ovf",  c_ovf,  0);
    chk("cor_wrap_reread", w_data, 11);

    // Clearing read colliding with an overflowing push
    do_reset();
    push = 5'b00010;
    tick(63);
    req = 1'b1; idx = 3'd1;
    tick();
    chk("cor_max_data", c_data, 63);
    push = '0;
    tick();
    req = 1'b0;
    chk("cor_max_reread", c_data, 1);
    chk("cor_max_ovf",    c_ovf,  0);
    chk("wrap_max_reread", w_data, 0);
    chk("wrap_max_ovf",    w_ovf,  5'b00010);

    // Reset during the third sweep word
    do_reset();
    push = 5'b11111;
    tick(3);
    push = '0;
    req = 1'b1; idx = 3'd5;
    tick();
    req = 1'b0;
    tick(2);
    chk("midrst_word2_data", w_data, 3);
    reset_L = 1'b0;
    tick();
    reset_L = 1'b1;
    chk("midrst_valid", w_valid, 0);
    chk("midrst_busy",  w_busy,  0);
    tick();
    chk("midrst_idle_valid", w_valid, 0);
    req = 1'b1; idx = 3'd5;
    tick();
    req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("midrst_cnt%0d", k),   w_data,  0);
      chk($sformatf("midrst_valid%0d", k), w_valid, 1);
      tick();
    end
    chk("midrst_done_busy", w_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
